// File: rtl/usb_rx_pkg.sv
// Shared constants for the USB receive deframer: header word, parser states, error codes.
package usb_rx_pkg;

    localparam logic [15:0] HDR_WORD = 16'hA55A;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CKSUM   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_CKSUM = 2'd2;

endpackage

// File: rtl/usb_rx_fifo.sv
// Show-ahead synchronous FIFO: the head word is visible the cycle after it is written.
// A push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
module usb_rx_fifo #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          drop
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == DEPTH);
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign rdata   = mem[rd_ptr_reg];

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/usb_rx_deframer.sv
// Buffers USB controller read words and parses [A55A][N][payload...][checksum] frames.
// Define USB_RX_CKSUM_EN to expect and verify the trailing checksum word.
module usb_rx_deframer
    import usb_rx_pkg::*;
#(
    parameter int FIFO_AW  = 4,
    parameter int MAX_LEN  = 512,
    parameter int AFULL_TH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        rx_stall,
    input  logic        ovf_clr,
    output logic        ovf,
    output logic [15:0] pl_data,
    output logic        pl_valid,
    input  logic        pl_ready,
    output logic        pl_last,
    output logic        frm_done,
    output logic        frm_err,
    output logic [1:0]  err_code
);

    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(2**FIFO_AW);

    logic [15:0]      head;
    logic             pop, full, empty, drop;
    logic [FIFO_AW:0] count, free_slots;

    state_t      state_reg, state_next;
    logic [10:0] rem_reg, rem_next;
    logic [1:0]  err_reg, err_next;
    logic        ovf_reg;
`ifdef USB_RX_CKSUM_EN
    logic [15:0] sum_reg, sum_next;
`endif

    usb_rx_fifo #(.AW(FIFO_AW), .DW(16)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count),
        .drop  (drop)
    );

    assign free_slots = DEPTH - count;
    assign rx_stall   = int'(free_slots) <= AFULL_TH;
    assign ovf        = ovf_reg;

    // A fresh drop wins over a simultaneous clear so no overflow is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_reg <= 1'b0;
        else if (drop)
            ovf_reg <= 1'b1;
        else if (ovf_clr)
            ovf_reg <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= HUNT;
            rem_reg   <= '0;
            err_reg   <= ERR_OK;
`ifdef USB_RX_CKSUM_EN
            sum_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            err_reg   <= err_next;
`ifdef USB_RX_CKSUM_EN
            sum_reg   <= sum_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        err_next   = err_reg;
`ifdef USB_RX_CKSUM_EN
        sum_next   = sum_reg;
`endif
        pop        = 1'b0;
        pl_valid   = 1'b0;
        pl_data    = '0;
        pl_last    = 1'b0;
        frm_done   = 1'b0;
        frm_err    = 1'b0;
        err_code   = ERR_OK;

        case (state_reg)
            HUNT: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head == HDR_WORD)
                        state_next = LEN;
                end
            end
            LEN: begin
                if (!empty) begin
                    pop      = 1'b1;
                    err_next = ERR_OK;
                    if (head > 16'(MAX_LEN)) begin
                        // Oversized length is reported immediately; nothing else of the frame is consumed.
                        frm_done   = 1'b1;
                        frm_err    = 1'b1;
                        err_code   = ERR_LEN;
                        state_next = HUNT;
                    end else if (head == '0) begin
`ifdef USB_RX_CKSUM_EN
                        sum_next   = '0;
                        state_next = CKSUM;
`else
                        state_next = DONE;
`endif
                    end else begin
                        rem_next   = head[10:0];
`ifdef USB_RX_CKSUM_EN
                        sum_next   = head;
`endif
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                pl_valid = !empty;
                if (!empty) begin
                    pl_data = head;
                    pl_last = (rem_reg == 11'd1);
                    if (pl_ready) begin
                        pop      = 1'b1;
                        rem_next = rem_reg - 11'd1;
`ifdef USB_RX_CKSUM_EN
                        sum_next = sum_reg + head;
                        if (rem_reg == 11'd1)
                            state_next = CKSUM;
`else
                        if (rem_reg == 11'd1)
                            state_next = DONE;
`endif
                    end
                end
            end
`ifdef USB_RX_CKSUM_EN
            CKSUM: begin
                if (!empty) begin
                    pop        = 1'b1;
                    err_next   = (head == sum_reg) ? ERR_OK : ERR_CKSUM;
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                frm_done   = 1'b1;
                frm_err    = (err_reg != ERR_OK);
                err_code   = err_reg;
                state_next = HUNT;
            end
            default: state_next = HUNT;
        endcase
    end

endmodule
